ram_arbiter: RTL and testbench

Round-robin controller that shares one single-port synchronous RAM between NUM_REQ requesters. After reset it clears the whole RAM, then grants one read or write per cycle using a valid/ready handshake, drives the RAM's registered write/read enables, and returns read data to the issuing requester. It sits between client engines and the RAM instance. The RAM instance is the existing single-port block, with datain, addr, wrt, rdd and clk inputs and a dataout output.

---
 rtl/ram_arbiter_pkg.sv | 20 ++
 rtl/ram_arbiter_if.sv | 29 ++
 rtl/ram_arbiter_rr_arbiter.sv | 31 +++
 rtl/ram_arbiter.sv | 119 +++++++++++
 tb/tb_ram_arbiter.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared types and defaults for the RAM arbiter.
// Imported by the interface, the arbiter core and the top.
package ram_arbiter_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 6;
  localparam int DEF_NUM_REQ    = 4;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ID_W = id_width(DEF_NUM_REQ);

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bundle: command handshake plus read response.
// master = requester side, slave = arbiter side.
interface ram_arbiter_if
  import ram_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_REQ    = DEF_NUM_REQ
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/ram_arbiter_rr_arbiter.sv
// Combinational round-robin pick: search starts one past last_grant.
// Pointer state lives in the parent.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      id
);

  logic found;

  always_comb begin
    grant = '0;
    id    = last_grant;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req[i] &&
            ((int'(last_grant) + k) % NUM_REQ) == i) begin
          found    = 1'b1;
          grant[i] = 1'b1;
          id       = IW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Clears the RAM after reset, then shares it round-robin between
// requesters; read data returns two cycles after acceptance.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_REQ    = DEF_NUM_REQ
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ram_arbiter_if.slave          bus,
  output logic                  init_done,
  output logic [DATA_WIDTH-1:0] ram_datain,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_wrt,
  output logic                  ram_rdd,
  input  logic [DATA_WIDTH-1:0] ram_dataout
);

  localparam int IW = id_width(NUM_REQ);
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  state_t                state;
  state_t                state_nx;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [IW-1:0]         last_grant;
  logic [IW-1:0]         win_id;
  logic [IW-1:0]         tag;
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    tag_hot;
  logic                  clr_en;
  logic                  run_en;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] addr_a [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_a [NUM_REQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= INIT;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      INIT: if (cnt == LAST) state_nx = RUN;
      RUN:  state_nx = RUN;
      default: state_nx = INIT;
    endcase
  end

  // Grants open only once init_done is visible to requesters.
  always_comb begin
    clr_en = (state == INIT);
    run_en = (state == RUN) && init_done;
  end

  assign req = bus.req_valid & {NUM_REQ{run_en}};

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr (
    .req        (req),
    .last_grant (last_grant),
    .grant      (grant),
    .id         (win_id)
  );

  assign bus.req_ready = grant;
  assign accept        = |grant;
  assign bus.rsp_rdata = ram_dataout;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_a[i]  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_a[i] = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    tag_hot      = '0;
    tag_hot[tag] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      last_grant    <= IW'(NUM_REQ - 1);
      tag           <= '0;
      init_done     <= 1'b0;
      ram_wrt       <= 1'b0;
      ram_rdd       <= 1'b0;
      ram_addr      <= '0;
      ram_datain    <= '0;
      bus.rsp_valid <= '0;
    end else begin
      init_done     <= (state == RUN);
      bus.rsp_valid <= ram_rdd ? tag_hot : '0;
      ram_wrt       <= 1'b0;
      ram_rdd       <= 1'b0;
      if (clr_en) begin
        ram_wrt    <= 1'b1;
        ram_addr   <= cnt;
        ram_datain <= '0;
        cnt        <= cnt + 1'b1;
      end else if (accept) begin
        ram_wrt    <= bus.req_we[win_id];
        ram_rdd    <= ~bus.req_we[win_id];
        ram_addr   <= addr_a[win_id];
        ram_datain <= wdata_a[win_id];
        tag        <= win_id;
        last_grant <= win_id;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: vector table, random traffic against a
// queue-style reference model, and reset/init sequences.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  localparam int DW = 8;
  localparam int AW = 6;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic          init_done;
  logic [DW-1:0] ram_datain;
  logic [AW-1:0] ram_addr;
  logic          ram_wrt;
  logic          ram_rdd;
  logic [DW-1:0] ram_dataout;

  ram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(N)) bus ();

  ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .init_done   (init_done),
    .ram_datain  (ram_datain),
    .ram_addr    (ram_addr),
    .ram_wrt     (ram_wrt),
    .ram_rdd     (ram_rdd),
    .ram_dataout (ram_dataout)
  );

  // Single-port synchronous RAM block, seeded with garbage
  logic [DW-1:0] mem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    ram_dataout = '0;
  end
  always @(posedge clk) begin
    if (ram_wrt) mem[ram_addr] <= ram_datain;
    if (ram_rdd) ram_dataout <= mem[ram_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [IW-1:0] lg;
  logic [DW-1:0] ref_mem [DEPTH];
  logic [N-1:0]  sv [3];
  logic [DW-1:0] sd [3];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    lg = IW'(N - 1);
    for (int i = 0; i < 3; i++) begin
      sv[i] = '0;
      sd[i] = '0;
    end
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  // One cycle, entered and left at a falling edge
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] we,
                      input logic [N*AW-1:0] a, input logic [N*DW-1:0] d,
                      output logic [N-1:0] rdy, output logic [N-1:0] rv,
                      output logic [DW-1:0] rd);
    logic [IW-1:0] j;
    logic [IW-1:0] g;
    logic          hit;
    logic [N-1:0]  er;
    logic [AW-1:0] ga;
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    #1;
    rdy = bus.req_ready;
    rv  = bus.rsp_valid;
    rd  = bus.rsp_rdata;
    chk("rsp_valid", 32'(rv), 32'(sv[0]));
    if (sv[0] != '0) chk("rsp_rdata", 32'(rd), 32'(sd[0]));
    hit = 1'b0;
    g   = '0;
    for (int k = 1; k <= N; k++) begin
      j = IW'((int'(lg) + k) % N);
      if (!hit && v[j]) begin
        hit = 1'b1;
        g   = j;
      end
    end
    er = '0;
    if (hit) er[g] = 1'b1;
    chk("req_ready", 32'(rdy), 32'(er));
    chk("ready_onehot", 32'($countones(rdy) <= 1), 32'd1);
    sv[2] = '0;
    sd[2] = '0;
    if (hit) begin
      lg = g;
      ga = a[g*AW +: AW];
      if (we[g]) ref_mem[ga] = d[g*DW +: DW];
      else begin
        sv[2] = er;
        sd[2] = ref_mem[ga];
      end
    end
    @(negedge clk);
    sv[0] = sv[1]; sd[0] = sd[1];
    sv[1] = sv[2]; sd[1] = sd[2];
  endtask

  // Reset pulse from a falling edge, then walk the whole clear
  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_we    = '0;
    #1;
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_ram_wrt", 32'(ram_wrt), 32'd0);
    chk("rst_ram_rdd", 32'(ram_rdd), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_datain", 32'(ram_datain), 32'd0);
    @(negedge clk);
    chk("rst_hold_rsp", 32'(bus.rsp_valid), 32'd0);
    rst_n = 1'b1;
    bus.req_valid = '1;
    #1;
    chk("pre_init_wrt", 32'(ram_wrt), 32'd0);
    for (int k = 1; k <= DEPTH; k++) begin
      @(negedge clk);
      chk("init_wrt", 32'(ram_wrt), 32'd1);
      chk("init_addr", 32'(ram_addr), 32'(k - 1));
      chk("init_data", 32'(ram_datain), 32'd0);
      chk("init_done_low", 32'(init_done), 32'd0);
      chk("init_ready", 32'(bus.req_ready), 32'd0);
      chk("init_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    @(negedge clk);
    chk("init_done_high", 32'(init_done), 32'd1);
    chk("post_init_wrt", 32'(ram_wrt), 32'd0);
    bus.req_valid = '0;
    model_reset();
  endtask

  typedef struct {
    logic [N-1:0]  v;
    logic [N-1:0]  we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [N-1:0]  rdy;
    logic [N-1:0]  rsp;
    logic [DW-1:0] rd;
  } vec_t;

  vec_t tbl [$];

  logic [N-1:0]    rdy, rv;
  logic [DW-1:0]   rd;
  logic [N-1:0]    pv, pwe;
  logic [AW-1:0]   pa [N];
  logic [DW-1:0]   pd [N];
  logic [N*AW-1:0] ap;
  logic [N*DW-1:0] dp;

  initial begin
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    model_reset();

    tbl.push_back('{4'b0100, 4'b0100, 6'h10, 8'hA5, 4'b0100, 4'b0000, 8'h00});
    tbl.push_back('{4'b0100, 4'b0000, 6'h10, 8'h00, 4'b0100, 4'b0000, 8'h00});
    tbl.push_back('{4'b0000, 4'b0000, 6'h00, 8'h00, 4'b0000, 4'b0000, 8'h00});
    tbl.push_back('{4'b1000, 4'b0000, 6'h00, 8'h00, 4'b1000, 4'b0100, 8'hA5});
    tbl.push_back('{4'b1111, 4'b0000, 6'h00, 8'h00, 4'b0001, 4'b0000, 8'h00});
    tbl.push_back('{4'b1111, 4'b0000, 6'h00, 8'h00, 4'b0010, 4'b1000, 8'h00});
    tbl.push_back('{4'b1111, 4'b0000, 6'h00, 8'h00, 4'b0100, 4'b0001, 8'h00});
    tbl.push_back('{4'b1111, 4'b0000, 6'h00, 8'h00, 4'b1000, 4'b0010, 8'h00});
    tbl.push_back('{4'b1111, 4'b0000, 6'h00, 8'h00, 4'b0001, 4'b0100, 8'h00});
    tbl.push_back('{4'b1111, 4'b0000, 6'h00, 8'h00, 4'b0010, 4'b1000, 8'h00});
    tbl.push_back('{4'b1111, 4'b0000, 6'h00, 8'h00, 4'b0100, 4'b0001, 8'h00});
    tbl.push_back('{4'b1111, 4'b0000, 6'h00, 8'h00, 4'b1000, 4'b0010, 8'h00});
    tbl.push_back('{4'b1010, 4'b1010, 6'h20, 8'h5C, 4'b0010, 4'b0100, 8'h00});
    tbl.push_back('{4'b1010, 4'b1010, 6'h20, 8'h5C, 4'b1000, 4'b1000, 8'h00});
    tbl.push_back('{4'b0010, 4'b0010, 6'h20, 8'h5C, 4'b0010, 4'b0000, 8'h00});
    tbl.push_back('{4'b0010, 4'b0010, 6'h20, 8'h5C, 4'b0010, 4'b0000, 8'h00});
    tbl.push_back('{4'b0000, 4'b0000, 6'h00, 8'h00, 4'b0000, 4'b0000, 8'h00});
    tbl.push_back('{4'b0000, 4'b0000, 6'h00, 8'h00, 4'b0000, 4'b0000, 8'h00});
    tbl.push_back('{4'b0011, 4'b0011, 6'h20, 8'h5C, 4'b0001, 4'b0000, 8'h00});
    tbl.push_back('{4'b0010, 4'b0010, 6'h20, 8'h5C, 4'b0010, 4'b0000, 8'h00});
    tbl.push_back('{4'b0001, 4'b0001, 6'h01, 8'h11, 4'b0001, 4'b0000, 8'h00});
    tbl.push_back('{4'b0010, 4'b0010, 6'h02, 8'h22, 4'b0010, 4'b0000, 8'h00});
    tbl.push_back('{4'b0100, 4'b0100, 6'h03, 8'h33, 4'b0100, 4'b0000, 8'h00});
    tbl.push_back('{4'b0001, 4'b0000, 6'h01, 8'h00, 4'b0001, 4'b0000, 8'h00});
    tbl.push_back('{4'b0010, 4'b0000, 6'h02, 8'h00, 4'b0010, 4'b0000, 8'h00});
    tbl.push_back('{4'b0100, 4'b0000, 6'h03, 8'h00, 4'b0100, 4'b0001, 8'h11});
    tbl.push_back('{4'b0000, 4'b0000, 6'h00, 8'h00, 4'b0000, 4'b0010, 8'h22});
    tbl.push_back('{4'b0000, 4'b0000, 6'h00, 8'h00, 4'b0000, 4'b0100, 8'h33});
    tbl.push_back('{4'b0001, 4'b0001, 6'h3F, 8'h7E, 4'b0001, 4'b0000, 8'h00});
    tbl.push_back('{4'b1000, 4'b0000, 6'h3F, 8'h00, 4'b1000, 4'b0000, 8'h00});
    tbl.push_back('{4'b0000, 4'b0000, 6'h00, 8'h00, 4'b0000, 4'b0000, 8'h00});
    tbl.push_back('{4'b0000, 4'b0000, 6'h00, 8'h00, 4'b0000, 4'b1000, 8'h7E});

    @(negedge clk);
    do_reset();

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].we, {N{tbl[i].a}}, {N{tbl[i].d}}, rdy, rv, rd);
      chk($sformatf("tbl%0d_ready", i), 32'(rdy), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_rsp", i), 32'(rv), 32'(tbl[i].rsp));
      if (tbl[i].rsp != '0)
        chk($sformatf("tbl%0d_rdata", i), 32'(rd), 32'(tbl[i].rd));
    end

    pv  = '0;
    pwe = '0;
    for (int i = 0; i < N; i++) begin
      pa[i] = '0;
      pd[i] = '0;
    end
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && $urandom_range(0, 2) != 0) begin
          pv[i]  = 1'b1;
          pwe[i] = 1'($urandom_range(0, 1));
          pa[i]  = (c % 5 == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
          pd[i]  = DW'($urandom);
        end
      end
      for (int i = 0; i < N; i++) begin
        ap[i*AW +: AW] = pa[i];
        dp[i*DW +: DW] = pd[i];
      end
      step(pv, pwe, ap, dp, rdy, rv, rd);
      pv = pv & ~rdy;
    end
    for (int c = 0; c < 3; c++) step('0, '0, '0, '0, rdy, rv, rd);

    // Read in flight when reset hits: must be dropped
    step(4'b0001, 4'b0000, {N{6'h10}}, '0, rdy, rv, rd);
    chk("midrst_accept", 32'(rdy), 32'b0001);
    do_reset();
    step(4'b1111, 4'b0000, {N{6'h10}}, '0, rdy, rv, rd);
    chk("first_grant_after_rst", 32'(rdy), 32'b0001);
    step(4'b0010, 4'b0000, {N{6'h3F}}, '0, rdy, rv, rd);
    step('0, '0, '0, '0, rdy, rv, rd);
    chk("cleared_rsp0", 32'(rv), 32'b0001);
    chk("cleared_data0", 32'(rd), 32'h00);
    step('0, '0, '0, '0, rdy, rv, rd);
    chk("cleared_rsp1", 32'(rv), 32'b0010);
    chk("cleared_data1", 32'(rd), 32'h00);
    step('0, '0, '0, '0, rdy, rv, rd);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
